bj_resolve_unit: RTL
====================

Name: bj_resolve_unit

Overview:
- Parametrised, pipelined successor to the combinational branch/jump condition detector.
- Resolves RISC-V branch and jump conditions at XLEN width and computes the branch/jump target and redirect PC.
- Compares the result against the front-end prediction and flags mispredictions and misaligned targets.
- Sits between the execute-stage operand mux and the fetch redirect logic, with valid/ready handshakes, a flush input and saturating performance counters.

Parameters:
- XLEN, 32, operand/PC width
- STAGES, 1, pipeline depth (1 or 2); latency in cycles from input handshake to OUT_VALID
- HAS_C, 0, 1 = compressed ISA (target alignment 2 B), 0 = alignment 4 B
- CNT_W, 32, performance counter width

Ports:
- CLK  in  1  clock
- RESET_N  in  1  asynchronous active-low reset
- IN_VALID  in  1  request valid
- IN_READY  out  1  unit can accept a request
- BRANCH_JUMP  in  3  op: 000 BEQ, 001 BNE, 010 none, 011 JAL/JALR, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
- IS_JALR  in  1  with op 011: target = (DATA1+IMM)&~1
- DATA1, DATA2  in  XLEN  rs1/rs2 operands
- PC  in  XLEN  instruction PC
- IMM  in  XLEN  sign-extended immediate
- PRED_TAKEN  in  1  front-end prediction
- PRED_TARGET  in  XLEN  predicted target
- FLUSH  in  1  kill all in-flight requests
- OUT_READY  in  1  downstream accepts
- OUT_VALID  out  1  result valid
- OUT_TAKEN  out  1  resolved taken
- OUT_REDIRECT_PC  out  XLEN  taken ? target : PC+4 (PC+2 not supported; always +4)
- OUT_MISPREDICT  out  1  prediction wrong
- OUT_MISALIGNED  out  1  taken target misaligned
- CNT_CLR  in  1  synchronous counter clear
- BRANCH_CNT  out  CNT_W  resolved ops with op≠010
- MISPRED_CNT  out  CNT_W  mispredicts

Behaviour:
- Reset: OUT_VALID=0; all payload regs and counters 0; IN_READY=1 after reset deassertion.
- Conditions: eq = DATA1==DATA2; lt = signed compare; ltu = unsigned compare.
  - Op 110/111 use ltu; op 100/101 use lt.
  - Op 011: always taken. Op 010: never taken; it never mispredicts unless PRED_TAKEN=1.
- Target:
  - Branch or JAL: PC+IMM.
  - JALR: (DATA1+IMM) with bit0 cleared.
  - All additions mod 2^XLEN; wrap-around is silent.
- OUT_MISPREDICT = (taken≠PRED_TAKEN) | (taken & target≠PRED_TARGET).
- OUT_MISALIGNED = taken & (HAS_C ? target[0] : |target[1:0]). When set, OUT_MISPREDICT is still reported.
- STAGES=1:
  - Everything is computed combinationally and captured in the output register on an input handshake.
  - Latency 1 cycle.
- STAGES=2:
  - Stage A registers eq/lt/ltu, the raw target, PC+4 and the prediction fields.
  - Stage B computes taken/mispredict/misaligned and registers them.
  - Latency 2 cycles.
- Handshake, per stage:
  - A stage loads when empty or when its content moves on the same cycle.
  - IN_READY = ~stage0_valid | stage0_advances. This is full throughput: one op/cycle while OUT_READY=1.
  - Payload is held stable while OUT_VALID & ~OUT_READY.
- FLUSH:
  - Clears every stage valid bit at the next edge; payload regs are don't-care.
  - IN_READY=0 in a FLUSH cycle, so no input is accepted.
  - FLUSH with an output handshake in the same cycle: the output is dropped and counters are not updated.
- Counters:
  - Increment on the output handshake only (OUT_VALID & OUT_READY & ~FLUSH). BRANCH_CNT skips op 010.
  - Saturate at all-ones.
  - CNT_CLR has priority over increment; the counter reads 0 the following cycle.
- Reset mid-operation: asynchronous clear of all valids and counters; no partial results emitted.
- Out-of-range STAGES (not 1 or 2): elaboration error.

Decomposition:
- Shared package bj_pkg:
  - bj_op_e enum for the eight BRANCH_JUMP encodings.
  - BJ_OP_W=3.
  - Function bj_taken(op, eq, lt, ltu), also usable by the reference model.
- One sub-module bj_pipe_stage (valid/ready register slice, parametrised payload width, flush input). It is instantiated STAGES times.

Test Plan:
- BEQ, DATA1=DATA2=0x5, PC=0x1000, IMM=0x20, PRED_TAKEN=0 -> after STAGES cycles: OUT_TAKEN=1, OUT_REDIRECT_PC=0x1020, OUT_MISPREDICT=1, MISPRED_CNT=1.
- BLT vs BLTU with DATA1=0xFFFFFFFF, DATA2=0x1 -> BLT taken=1, BLTU taken=0. BGE/BGEU are the inverse.
- JALR, DATA1=0x2003, IMM=0x0, PRED_TAKEN=1, PRED_TARGET=0x2002, HAS_C=0 -> target 0x2002, OUT_MISALIGNED=1, OUT_MISPREDICT=0.
- Back-to-back 8 ops with OUT_READY toggling 1,0,0,1… -> no loss or duplication; payload stable while stalled; BRANCH_CNT=8.
- FLUSH asserted with 2 ops in flight (STAGES=2) and IN_VALID=1 -> next cycle OUT_VALID=0, IN_READY was 0 during FLUSH, counters unchanged.
- Counter saturation (CNT_W=4, 17 mispredicts) -> MISPRED_CNT=0xF. CNT_CLR together with a handshake -> 0. Async RESET_N low mid-stream -> OUT_VALID=0 immediately.

Source files
------------

// File: rtl/bj_pkg.sv
// rtl/bj_pkg.sv - shared op encodings and condition helper for the branch/jump resolve unit
package bj_pkg;

    localparam int BJ_OP_W = 3;

    typedef enum logic [BJ_OP_W-1:0] {
        OP_BEQ  = 3'b000,
        OP_BNE  = 3'b001,
        OP_NONE = 3'b010,
        OP_JUMP = 3'b011,
        OP_BLT  = 3'b100,
        OP_BGE  = 3'b101,
        OP_BLTU = 3'b110,
        OP_BGEU = 3'b111
    } bj_op_e;

    function automatic logic bj_taken(bj_op_e op, logic eq, logic lt, logic ltu);
        case (op)
            OP_BEQ:  bj_taken = eq;
            OP_BNE:  bj_taken = ~eq;
            OP_NONE: bj_taken = 1'b0;
            OP_JUMP: bj_taken = 1'b1;
            OP_BLT:  bj_taken = lt;
            OP_BGE:  bj_taken = ~lt;
            OP_BLTU: bj_taken = ltu;
            default: bj_taken = ~ltu;
        endcase
    endfunction

endpackage

// File: rtl/bj_resolve_unit_if.sv
// rtl/bj_resolve_unit_if.sv - request/result handshake bundle between operand mux and fetch redirect
interface bj_resolve_unit_if #(parameter int XLEN = 32);
    import bj_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [BJ_OP_W-1:0]  branch_jump;
    logic                is_jalr;
    logic [XLEN-1:0]     data1;
    logic [XLEN-1:0]     data2;
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     imm;
    logic                pred_taken;
    logic [XLEN-1:0]     pred_target;
    logic                out_ready;
    logic                out_valid;
    logic                out_taken;
    logic [XLEN-1:0]     out_redirect_pc;
    logic                out_mispredict;
    logic                out_misaligned;

    modport master (
        output in_valid, branch_jump, is_jalr, data1, data2, pc, imm, pred_taken, pred_target, out_ready,
        input  in_ready, out_valid, out_taken, out_redirect_pc, out_mispredict, out_misaligned
    );

    modport slave (
        input  in_valid, branch_jump, is_jalr, data1, data2, pc, imm, pred_taken, pred_target, out_ready,
        output in_ready, out_valid, out_taken, out_redirect_pc, out_mispredict, out_misaligned
    );
endinterface

// File: rtl/bj_pipe_stage.sv
// rtl/bj_pipe_stage.sv - valid/ready register slice with flush
module bj_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data
);
    logic         valid_q;
    logic [W-1:0] data_q;

    // Load when empty or when the current content leaves this cycle.
    assign s_ready = ~valid_q | m_ready;
    assign m_valid = valid_q;
    assign m_data  = data_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            if (flush)
                valid_q <= 1'b0;
            else if (s_ready)
                valid_q <= s_valid;
            if (s_ready && s_valid && !flush)
                data_q <= s_data;
        end
    end
endmodule

// File: rtl/bj_resolve_unit.sv
// rtl/bj_resolve_unit.sv - pipelined branch/jump resolve with mispredict detection and perf counters
module bj_resolve_unit
    import bj_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 1,
    parameter int HAS_C  = 0,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    bj_resolve_unit_if.slave bus,
    input  logic             flush,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);
    localparam int A_W   = BJ_OP_W + 4 + 3 * XLEN;
    localparam int RES_W = XLEN + 4;

    logic [XLEN-1:0]    f_target, f_pc4, jalr_sum;
    logic               f_eq, f_lt, f_ltu;

    logic [BJ_OP_W-1:0] r_op;
    logic               r_eq, r_lt, r_ltu, r_pred_taken;
    logic [XLEN-1:0]    r_target, r_pc4, r_pred_target;
    logic               r_taken, r_mispredict, r_misaligned;
    logic [XLEN-1:0]    r_redirect;

    logic               fin_s_valid, fin_s_ready, stage0_ready;
    logic [RES_W-1:0]   res_d, res_q;
    logic               out_is_branch, fire;

    assign f_eq     = bus.data1 == bus.data2;
    assign f_lt     = $signed(bus.data1) < $signed(bus.data2);
    assign f_ltu    = bus.data1 < bus.data2;
    assign jalr_sum = bus.data1 + bus.imm;
    assign f_target = (bus.is_jalr && bus.branch_jump == OP_JUMP) ? {jalr_sum[XLEN-1:1], 1'b0}
                                                                 : bus.pc + bus.imm;
    assign f_pc4    = bus.pc + XLEN'(4);

    generate
        if (STAGES == 1) begin : g_one
            assign r_op          = bus.branch_jump;
            assign r_eq          = f_eq;
            assign r_lt          = f_lt;
            assign r_ltu         = f_ltu;
            assign r_pred_taken  = bus.pred_taken;
            assign r_target      = f_target;
            assign r_pc4         = f_pc4;
            assign r_pred_target = bus.pred_target;
            assign fin_s_valid   = bus.in_valid & ~flush;
            assign stage0_ready  = fin_s_ready;
        end else if (STAGES == 2) begin : g_two
            logic [A_W-1:0] a_q;
            logic           a_valid, a_ready;

            // Stage A holds raw compare flags and addresses; decisions happen in stage B.
            bj_pipe_stage #(.W(A_W)) u_stage_a (
                .clk     (clk),
                .reset_n (reset_n),
                .flush   (flush),
                .s_valid (bus.in_valid & ~flush),
                .s_ready (a_ready),
                .s_data  ({bus.branch_jump, f_eq, f_lt, f_ltu, bus.pred_taken,
                           f_target, f_pc4, bus.pred_target}),
                .m_valid (a_valid),
                .m_ready (fin_s_ready),
                .m_data  (a_q)
            );

            assign {r_op, r_eq, r_lt, r_ltu, r_pred_taken, r_target, r_pc4, r_pred_target} = a_q;
            assign fin_s_valid  = a_valid;
            assign stage0_ready = a_ready;
        end else begin : g_bad
            $error("bj_resolve_unit: STAGES must be 1 or 2");
        end
    endgenerate

    always_comb begin
        r_taken      = bj_taken(bj_op_e'(r_op), r_eq, r_lt, r_ltu);
        r_mispredict = (r_taken != r_pred_taken) || (r_taken && (r_target != r_pred_target));
        r_misaligned = r_taken && ((HAS_C != 0) ? r_target[0] : |r_target[1:0]);
        r_redirect   = r_taken ? r_target : r_pc4;
        res_d        = {r_op != OP_NONE, r_taken, r_mispredict, r_misaligned, r_redirect};
    end

    bj_pipe_stage #(.W(RES_W)) u_stage_out (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .s_valid (fin_s_valid),
        .s_ready (fin_s_ready),
        .s_data  (res_d),
        .m_valid (bus.out_valid),
        .m_ready (bus.out_ready),
        .m_data  (res_q)
    );

    assign {out_is_branch, bus.out_taken, bus.out_mispredict, bus.out_misaligned, bus.out_redirect_pc} = res_q;
    assign bus.in_ready = stage0_ready & ~flush;

    // A result leaving during a flush is discarded and must not be counted.
    assign fire = bus.out_valid & bus.out_ready & ~flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (cnt_clr) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (fire) begin
            if (out_is_branch && branch_cnt != '1)
                branch_cnt <= branch_cnt + CNT_W'(1);
            if (bus.out_mispredict && mispred_cnt != '1)
                mispred_cnt <= mispred_cnt + CNT_W'(1);
        end
    end
endmodule
